// File: rtl/text_terminal_buffer_if.sv
// Purpose: bundles the byte-stream handshake, cursor and pixel-pipeline signals of text_terminal_buffer.
// Latency: none; this is wiring only.
// Backpressure: char_ready/char_valid handshake; the pixel path has no backpressure.
// Ports:
//   byte side  : char_valid, char_ready, char_code, clear_req
//   cursor     : cursor_en, cursor_col, cursor_row
//   pixel side : pixel_valid, pixel_hpos, pixel_vpos, pixel_color_valid, pixel_color
`timescale 1ns/1ps
interface text_terminal_buffer_if #(
    parameter int COL_W        = 7,
    parameter int ROW_W        = 5,
    parameter int PIXEL_HPOS_W = 10,
    parameter int PIXEL_VPOS_W = 10
);
    logic                    char_valid;
    logic                    char_ready;
    logic [7:0]              char_code;
    logic                    clear_req;
    logic                    cursor_en;
    logic [COL_W-1:0]        cursor_col;
    logic [ROW_W-1:0]        cursor_row;
    logic                    pixel_valid;
    logic [PIXEL_HPOS_W-1:0] pixel_hpos;
    logic [PIXEL_VPOS_W-1:0] pixel_vpos;
    logic                    pixel_color_valid;
    logic                    pixel_color;

    modport master (
        output char_valid, char_code, clear_req, cursor_en,
               pixel_valid, pixel_hpos, pixel_vpos,
        input  char_ready, cursor_col, cursor_row, pixel_color_valid, pixel_color
    );

    modport slave (
        input  char_valid, char_code, clear_req, cursor_en,
               pixel_valid, pixel_hpos, pixel_vpos,
        output char_ready, cursor_col, cursor_row, pixel_color_valid, pixel_color
    );
endinterface

// File: rtl/text_terminal_buffer.sv
// Purpose: COLS x ROWS terminal text store fed by a byte stream, rendered to 1-bit pixels via character_rom.
// Latency: pixel_color is 2 cycles after pixel_hpos/pixel_vpos; a printable byte costs one bubble cycle.
// Backpressure: char_ready is high only in IDLE; WRITE/NEWLINE/SCROLL/CLEAR hold it low.
// Ports: clk, rst (synchronous, active-high), bus (text_terminal_buffer_if.slave).
// Optional macro TEXT_BUF_INVERSE_ATTR_EN: bit 7 of a stored byte selects inverse video for that cell.
`timescale 1ns/1ps

// Stand-in glyph source with the same port shape as the font ROM: a space is blank,
// any other code lights pixel (gx,gy) from code bit ((gx ^ gy) & 7).
module character_rom #(
    parameter int GX_W = 3,
    parameter int GY_W = 4
) (
    input  logic [7:0]      code,
    input  logic [GX_W-1:0] gx,
    input  logic [GY_W-1:0] gy,
    output logic            pixel
);
    logic [2:0] idx;

    assign idx   = 3'(int'(gx) ^ int'(gy));
    assign pixel = (code != 8'h20) && code[idx];
endmodule

module text_terminal_buffer #(
    parameter int CLK_FREQ          = 50_000_000,
    parameter int COLS              = 80,
    parameter int ROWS              = 25,
    parameter int GLYPH_W           = 8,
    parameter int GLYPH_H           = 16,
    parameter int SCALE             = 1,
    parameter int PIXEL_HPOS_W      = 10,
    parameter int PIXEL_VPOS_W      = 10,
    parameter int CURSOR_BLINK_FREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    text_terminal_buffer_if.slave bus
);
    localparam int COL_W       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CELLS       = COLS * ROWS;
    localparam int ADDR_W      = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int GX_W        = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int GY_W        = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int HALF_PERIOD = CLK_FREQ / CURSOR_BLINK_FREQ / 2;
    localparam int BLINK_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [PIXEL_HPOS_W-1:0] CELL_PX_W = PIXEL_HPOS_W'(GLYPH_W * SCALE);
    localparam logic [PIXEL_VPOS_W-1:0] CELL_PX_H = PIXEL_VPOS_W'(GLYPH_H * SCALE);
    localparam logic [PIXEL_HPOS_W-1:0] SCALE_H   = PIXEL_HPOS_W'(SCALE);
    localparam logic [PIXEL_VPOS_W-1:0] SCALE_V   = PIXEL_VPOS_W'(SCALE);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_NEWLINE = 3'd2;
    localparam logic [2:0] S_SCROLL  = 3'd3;
    localparam logic [2:0] S_CLEAR   = 3'd4;

    // Logical row r lives at physical row (r + off) mod ROWS, so scrolling is just an offset bump.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] r,
                                                  input logic [ROW_W-1:0] off);
        logic [ROW_W:0] s;
        s = {1'b0, r} + {1'b0, off};
        if (s >= (ROW_W+1)'(ROWS))
            s = s - (ROW_W+1)'(ROWS);
        return s[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(int'(prow) * COLS + int'(c));
    endfunction

    // ---------------- byte-stream FSM ----------------
    logic [2:0]        state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_offset;
    logic [7:0]        char_latch;
    logic [ADDR_W-1:0] clr_idx;
    logic [COL_W-1:0]  scroll_idx;
    logic              take;

    // clear_req wins over a byte offered in the same cycle by refusing the byte.
    assign bus.char_ready = (state == S_IDLE) && !bus.clear_req;
    assign take           = bus.char_valid && bus.char_ready;
    assign bus.cursor_col = col;
    assign bus.cursor_row = row;

    // A full 8-bit compare means a byte with bit 7 set is never a control code,
    // which is what inverse-video bytes need and is harmless without that feature.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            col        <= '0;
            row        <= '0;
            row_offset <= '0;
            char_latch <= 8'h20;
            clr_idx    <= '0;
            scroll_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.clear_req) begin
                        clr_idx <= '0;
                        state   <= S_CLEAR;
                    end else if (take) begin
                        if (bus.char_code == 8'h0A) begin
                            state <= S_NEWLINE;
                        end else if (bus.char_code == 8'h0D) begin
                            col <= '0;
                        end else if (bus.char_code == 8'h08) begin
                            if (col != '0)
                                col <= col - 1'b1;
                        end else begin
                            char_latch <= bus.char_code;
                            state      <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (col < COL_W'(COLS - 1)) begin
                        col   <= col + 1'b1;
                        state <= S_IDLE;
                    end else begin
                        col   <= '0;
                        state <= S_NEWLINE;
                    end
                end
                S_NEWLINE: begin
                    if (row < ROW_W'(ROWS - 1)) begin
                        row   <= row + 1'b1;
                        state <= S_IDLE;
                    end else begin
                        // The old top physical row becomes the new bottom row and is blanked in SCROLL.
                        row_offset <= (row_offset == ROW_W'(ROWS - 1)) ? '0 : row_offset + 1'b1;
                        scroll_idx <= '0;
                        state      <= S_SCROLL;
                    end
                end
                S_SCROLL: begin
                    if (scroll_idx == COL_W'(COLS - 1))
                        state <= S_IDLE;
                    else
                        scroll_idx <= scroll_idx + 1'b1;
                end
                S_CLEAR: begin
                    if (clr_idx == ADDR_W'(CELLS - 1)) begin
                        col        <= '0;
                        row        <= '0;
                        row_offset <= '0;
                        state      <= S_IDLE;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // ---------------- character RAM write port ----------------
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = 8'h20;
        case (state)
            S_WRITE: begin
                we    = 1'b1;
                waddr = cell_addr(phys_row(row, row_offset), col);
                wdata = char_latch;
            end
            S_SCROLL: begin
                // row is pinned at the bottom here and row_offset is already advanced.
                we    = 1'b1;
                waddr = cell_addr(phys_row(row, row_offset), scroll_idx);
            end
            S_CLEAR: begin
                we    = 1'b1;
                waddr = clr_idx;
            end
            default: ;
        endcase
    end

    // ---------------- cursor blink ----------------
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt <= BLINK_W'(HALF_PERIOD - 1);
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt - 1'b1;
        end
    end

    // ---------------- pixel pipeline stage 1 ----------------
    logic [PIXEL_HPOS_W-1:0] cell_x;
    logic [PIXEL_VPOS_W-1:0] cell_y;
    logic [GX_W-1:0]         gx;
    logic [GY_W-1:0]         gy;
    logic                    in_area;
    logic                    cursor_hit;
    logic [ADDR_W-1:0]       rd_addr;

    assign cell_x  = bus.pixel_hpos / CELL_PX_W;
    assign cell_y  = bus.pixel_vpos / CELL_PX_H;
    assign gx      = GX_W'((bus.pixel_hpos % CELL_PX_W) / SCALE_H);
    assign gy      = GY_W'((bus.pixel_vpos % CELL_PX_H) / SCALE_V);
    assign in_area = (cell_x < PIXEL_HPOS_W'(COLS)) && (cell_y < PIXEL_VPOS_W'(ROWS));
    assign rd_addr = in_area ? cell_addr(phys_row(ROW_W'(cell_y), row_offset), COL_W'(cell_x)) : '0;

    // The cursor is an underline on the bottom two glyph lines of the cursor cell.
    assign cursor_hit = bus.cursor_en && blink_on && in_area
                     && (COL_W'(cell_x) == col) && (ROW_W'(cell_y) == row)
                     && (gy >= GY_W'(GLYPH_H - 2));

    logic [7:0] mem [CELLS];
    logic [7:0] rd_data;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rd_data <= mem[rd_addr];
    end

    logic            s1_vld;
    logic            s1_area;
    logic            s1_hit;
    logic [GX_W-1:0] s1_gx;
    logic [GY_W-1:0] s1_gy;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_area <= 1'b0;
            s1_hit  <= 1'b0;
            s1_gx   <= '0;
            s1_gy   <= '0;
        end else begin
            s1_vld  <= bus.pixel_valid;
            s1_area <= in_area;
            s1_hit  <= cursor_hit;
            s1_gx   <= gx;
            s1_gy   <= gy;
        end
    end

    // ---------------- pixel pipeline stage 2 ----------------
    logic [7:0] rom_code;
    logic       inverse;
    logic       glyph_px;

`ifdef TEXT_BUF_INVERSE_ATTR_EN
    assign rom_code = {1'b0, rd_data[6:0]};
    assign inverse  = rd_data[7];
`else
    assign rom_code = rd_data;
    assign inverse  = 1'b0;
`endif

    character_rom #(
        .GX_W (GX_W),
        .GY_W (GY_W)
    ) u_character_rom (
        .code  (rom_code),
        .gx    (s1_gx),
        .gy    (s1_gy),
        .pixel (glyph_px)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pixel_color_valid <= 1'b0;
            bus.pixel_color       <= 1'b0;
        end else begin
            bus.pixel_color_valid <= s1_vld;
            bus.pixel_color       <= s1_vld && s1_area && (glyph_px ^ s1_hit ^ inverse);
        end
    end
endmodule

// File: tb/tb_text_terminal_buffer.sv
// Purpose: randomized self-checking bench for text_terminal_buffer against a logical-screen model.
// Latency: expects pixel results 2 cycles after drive and one bubble per printable byte.
// Backpressure: waits on char_ready with bounded loops before and after each byte.
`timescale 1ns/1ps
module tb_text_terminal_buffer;
    localparam int COLS       = 8;
    localparam int ROWS       = 4;
    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 16;
    localparam int CLK_FREQ   = 8;
    localparam int BLINK_FREQ = 1;
    localparam int HP         = CLK_FREQ / BLINK_FREQ / 2;
    localparam int COL_W      = 3;
    localparam int ROW_W      = 2;
    localparam int CELLS      = COLS * ROWS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    text_terminal_buffer_if #(
        .COL_W(COL_W), .ROW_W(ROW_W), .PIXEL_HPOS_W(10), .PIXEL_VPOS_W(10)
    ) bus ();

    text_terminal_buffer #(
        .CLK_FREQ(CLK_FREQ), .COLS(COLS), .ROWS(ROWS), .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H),
        .SCALE(1), .PIXEL_HPOS_W(10), .PIXEL_VPOS_W(10), .CURSOR_BLINK_FREQ(BLINK_FREQ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model: logical screen, row 0 on top ----------------
    logic [7:0] scr [ROWS][COLS];
    int         m_col, m_row;
    int         n_chk, n_pass;
    int         nedge;
    int         pxh [256];
    int         pxy [256];
    bit         pxv [256];

    // Clock edges since reset release; the blink phase follows from this count alone.
    always @(posedge clk) begin
        if (rst) nedge <= 0;
        else     nedge <= nedge + 1;
    end

    function automatic bit blink_phase(input int n);
        if (n == 0) return 1'b0;
        return (((n - 1) / HP) % 2) == 0;
    endfunction

    function automatic bit rom_px(input logic [7:0] b, input int gx, input int gy);
        if (b == 8'h20) return 1'b0;
        return b[(gx ^ gy) & 7];
    endfunction

    function automatic bit exp_px(input bit v, input int h, input int y, input bit cen, input bit ph);
        int cx, cy, gy;
        bit g, hit;
        if (!v) return 1'b0;
        cx = h / GLYPH_W;
        cy = y / GLYPH_H;
        if (cx >= COLS || cy >= ROWS) return 1'b0;
        gy  = y % GLYPH_H;
        g   = rom_px(scr[cy][cx], h % GLYPH_W, gy);
        hit = cen && ph && (cx == m_col) && (cy == m_row) && (gy >= GLYPH_H - 2);
        return g ^ hit;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
        m_col = 0;
        m_row = 0;
    endtask

    task automatic m_newline(output int bub);
        bub = 1;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++)
                scr[ROWS-1][c] = 8'h20;
            bub += COLS;
        end
    endtask

    task automatic m_put(input logic [7:0] b, output int bub);
        int nb;
        bub = 0;
        if (b == 8'h0A) begin
            m_newline(bub);
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else begin
            scr[m_row][m_col] = b;
            bub = 1;
            if (m_col < COLS - 1) begin
                m_col++;
            end else begin
                m_col = 0;
                m_newline(nb);
                bub += nb;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_cursor"}, {bus.cursor_row, bus.cursor_col},
              {m_row[ROW_W-1:0], m_col[COL_W-1:0]});
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (bus.char_ready !== 1'b1 && n < 2 * CELLS) begin
            tick();
            n++;
        end
        check({tag, "_clear_len"}, n, CELLS);
        check_cursor(tag);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        int bub, n;
        n = 0;
        bus.char_valid = 1'b1;
        bus.char_code  = b;
        while (bus.char_ready !== 1'b1 && n < 2 * CELLS) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, bus.char_ready, 1'b1);
        tick();
        bus.char_valid = 1'b0;
        m_put(b, bub);
        n = 0;
        while (bus.char_ready !== 1'b1 && n < 2 * CELLS) begin
            tick();
            n++;
        end
        check({tag, "_bubbles"}, n, bub);
        check_cursor(tag);
    endtask

    // Streams pxv/pxh/pxy[0..n-1], one per cycle, and compares the 2-cycle-late outputs.
    task automatic run_px(input int n, input bit cen, input string tag);
        logic [255:0] obs, expv, vobs, vexp;
        obs = '0; expv = '0; vobs = '0; vexp = '0;
        bus.cursor_en = cen;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                bus.pixel_valid = pxv[i];
                bus.pixel_hpos  = 10'(pxh[i]);
                bus.pixel_vpos  = 10'(pxy[i]);
                expv[i] = exp_px(pxv[i], pxh[i], pxy[i], cen, blink_phase(nedge));
                vexp[i] = pxv[i];
            end else begin
                bus.pixel_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                obs[i-1]  = bus.pixel_color;
                vobs[i-1] = bus.pixel_color_valid;
            end
        end
        tick();
        bus.cursor_en = 1'b0;
        check({tag, "_color"}, obs, expv);
        check({tag, "_pcv"}, vobs, vexp);
    endtask

    task automatic check_cell(input int r, input int c);
        for (int gy = 0; gy < GLYPH_H; gy++)
            for (int gx = 0; gx < GLYPH_W; gx++) begin
                pxv[gy*GLYPH_W + gx] = 1'b1;
                pxh[gy*GLYPH_W + gx] = c * GLYPH_W + gx;
                pxy[gy*GLYPH_W + gx] = r * GLYPH_H + gy;
            end
        run_px(GLYPH_W * GLYPH_H, 1'b0, $sformatf("cell_%0d_%0d", r, c));
    endtask

    task automatic check_screen();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                check_cell(r, c);
    endtask

    function automatic logic [7:0] rand_byte();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 8'h0A;
        if (k == 1) return 8'h0D;
        if (k == 2) return 8'h08;
        return 8'($urandom_range(33, 126));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        bus.char_valid  = 1'b0;
        bus.char_code   = 8'h00;
        bus.clear_req   = 1'b0;
        bus.cursor_en   = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_hpos  = '0;
        bus.pixel_vpos  = '0;
        rst = 1'b1;
        m_clear();
        repeat (3) tick();

        // Reset values.
        check("rst_ready", bus.char_ready, 1'b0);
        check("rst_pcv", bus.pixel_color_valid, 1'b0);
        check("rst_pc", bus.pixel_color, 1'b0);
        check_cursor("rst");
        rst = 1'b0;
        wait_clear("init");
        check_screen();

        // Single character and its glyph column 0.
        send_byte(8'h41, "A");
        for (int i = 0; i < GLYPH_H; i++) begin
            pxv[i] = 1'b1;
            pxh[i] = 0;
            pxy[i] = i;
        end
        run_px(GLYPH_H, 1'b0, "A_glyph");

        // Line wrap and control codes.
        send_byte(8'h0D, "cr0");
        for (int i = 0; i < COLS; i++) send_byte(8'h78, $sformatf("x%0d", i));
        send_byte(8'h0D, "cr");
        send_byte(8'h08, "bs");
        send_byte(8'h0A, "lf");

        // Blink on a glyph cell and on a blank cell, with and without cursor_en.
        send_byte(8'h4D, "M");
        send_byte(8'h08, "bs_m");
        for (int i = 0; i < 24; i++) begin
            pxv[i] = 1'b1;
            pxh[i] = m_col * GLYPH_W + 1;
            pxy[i] = m_row * GLYPH_H + 14 + (i % 2);
        end
        run_px(24, 1'b1, "blink_glyph_on");
        run_px(24, 1'b0, "blink_glyph_off");
        send_byte(8'h0D, "cr_b");
        send_byte(8'h0A, "lf_b");
        for (int i = 0; i < 24; i++) begin
            pxv[i] = 1'b1;
            pxh[i] = m_col * GLYPH_W + 3;
            pxy[i] = m_row * GLYPH_H + 15;
        end
        run_px(24, 1'b1, "blink_blank_on");
        run_px(24, 1'b0, "blink_blank_off");

        // Scroll: text on the bottom row, then LF from the bottom row.
        while (m_row < ROWS - 1) send_byte(8'h0A, "down");
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(33, 126)), "bot");
        send_byte(8'h0A, "scroll_lf");
        check_screen();

        // Random byte stream, then random pixels including blanking and out-of-area.
        for (int i = 0; i < 60; i++) send_byte(rand_byte(), $sformatf("rnd%0d", i));
        check_screen();
        for (int i = 0; i < 250; i++) begin
            pxv[i] = ($urandom_range(0, 3) != 0);
            pxh[i] = $urandom_range(0, 90);
            pxy[i] = $urandom_range(0, 90);
        end
        run_px(250, 1'($urandom_range(0, 1)), "rnd_px");

        // clear_req beats a simultaneous byte; the byte lands at 0/0 afterwards.
        bus.char_valid = 1'b1;
        bus.char_code  = 8'h51;
        bus.clear_req  = 1'b1;
        #1;
        check("clr_prio_ready", bus.char_ready, 1'b0);
        tick();
        bus.clear_req = 1'b0;
        m_clear();
        wait_clear("clr_req");
        send_byte(8'h51, "after_clr");
        check_cell(0, 0);
        check_cell(0, 1);

        // Reset in the middle of a scroll.
        while (m_row < ROWS - 1) send_byte(8'h0A, "down2");
        send_byte(8'h5A, "z");
        bus.char_valid = 1'b1;
        bus.char_code  = 8'h0A;
        tick();
        bus.char_valid = 1'b0;
        repeat (3) tick();
        check("mid_scroll_busy", bus.char_ready, 1'b0);
        rst = 1'b1;
        tick();
        m_clear();
        check_cursor("rst_scroll");
        check("rst_scroll_ready", bus.char_ready, 1'b0);
        rst = 1'b0;
        wait_clear("rst_scroll");
        check_screen();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/text_terminal_buffer.md
Name: text_terminal_buffer

Overview:
Parametrised successor to the fixed-grid text buffer: a COLS x ROWS character store written through a terminal-style byte stream with a ready/valid handshake. It handles cursor auto-advance, line wrap, CR/LF/backspace and hardware scroll. A 2-stage pipeline turns the VGA pixel coordinate into a glyph pixel via the existing character_rom. It sits between the UART/CPU byte source and the VGA timing generator.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz
COLS, 80, text columns
ROWS, 25, text rows
GLYPH_W, 8, glyph width in ROM pixels
GLYPH_H, 16, glyph height in ROM pixels
SCALE, 1, integer pixel replication factor, applied to both axes
PIXEL_HPOS_W, 10, pixel x width
PIXEL_VPOS_W, 10, pixel y width
CURSOR_BLINK_FREQ, 2, cursor blink frequency in Hz

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
char_valid  in  1  byte offered
char_ready  out  1  byte accepted when char_valid & char_ready
char_code  in  8  byte: printable character or control code
clear_req  in  1  one-cycle pulse: clear the screen and home the cursor
cursor_en  in  1  enables cursor rendering
cursor_col  out  clog2(COLS)  current cursor column
cursor_row  out  clog2(ROWS)  current cursor row (logical row, 0 = top)
pixel_valid  in  1  pixel_hpos/pixel_vpos valid (active video)
pixel_hpos  in  PIXEL_HPOS_W  pixel x
pixel_vpos  in  PIXEL_VPOS_W  pixel y
pixel_color_valid  out  1  pixel_valid delayed by 2 cycles
pixel_color  out  1  foreground = 1

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: cursor 0/0, row_offset 0, blink counter 0, blink phase off, pixel_color 0, pixel_color_valid 0, pipeline valids 0, char_ready 0. The FSM enters CLEAR.
- FSM states:
  - IDLE: char_ready = 1.
    - A handshake on a printable byte (0x20..0x7E, or any code not listed below) -> WRITE.
    - 0x0A -> NEWLINE.
    - 0x0D: col = 0, stay in IDLE.
    - 0x08: col = col - 1 if col > 0, else unchanged; no erase.
    - clear_req has priority over a simultaneous handshake; the byte is not accepted (char_ready = 0 that cycle) -> CLEAR.
  - WRITE (1 cycle): store the byte at physical row (row + row_offset) mod ROWS.
    - If col < COLS-1: col + 1 -> IDLE.
    - Else: col = 0 -> NEWLINE.
  - NEWLINE (1 cycle):
    - If row < ROWS-1: row + 1 -> IDLE.
    - Else: row_offset = (row_offset + 1) mod ROWS, row stays ROWS-1 -> SCROLL.
  - SCROLL: writes 0x20 to each of the COLS cells of the new bottom physical row, one per cycle (COLS cycles) -> IDLE.
  - CLEAR: writes 0x20 to all COLS*ROWS cells, one per cycle, then sets cursor 0/0 and row_offset 0 -> IDLE. clear_req during CLEAR is ignored.
- char_ready = 0 in every state except IDLE. A held byte must remain stable until accepted.
- Storage: synchronous-read RAM of COLS*ROWS bytes, indexed row*COLS + col. The write port belongs to the FSM; the read port belongs to the pixel pipeline.
- Pixel pipeline (latency 2):
  - S1 computes cell_x = hpos / (GLYPH_W*SCALE), cell_y = vpos / (GLYPH_H*SCALE) and the glyph sub-pixels gx, gy (remainders divided by SCALE), and issues the RAM read at physical row (cell_y + row_offset) mod ROWS.
  - S2 feeds the read byte and the delayed gx/gy to character_rom, then registers the result.
  - Coordinates with cell_x >= COLS or cell_y >= ROWS give pixel_color 0.
  - pixel_valid = 0 forces pixel_color 0.
- Cursor and blink:
  - Blink half period = CLK_FREQ / CURSOR_BLINK_FREQ / 2 cycles. The counter counts down from half_period-1; at 0 it reloads and toggles the phase.
  - When cursor_en & phase on & the pixel cell equals the cursor cell & gy >= GLYPH_H-2: pixel_color = glyph XOR 1.
- Cursor outputs update on the cycle after the state action and are registered.

Optional Feature:
TEXT_BUF_INVERSE_ATTR_EN
- Defined: char_code bit 7 is an inverse-video attribute. The ROM receives {1'b0, code[6:0]}, and pixel_color is inverted for that cell. Out-of-area pixels and blanking stay 0. Control-code decode uses code[6:0] only when bit 7 = 0.
- Undefined: all 8 bits go to the ROM unchanged and no inversion occurs.

Test Plan:
- Release rst, hold char_valid low -> char_ready = 0 for exactly COLS*ROWS cycles, then 1; cursor 0/0; every cell reads 0x20.
- Send 'A' (0x41) at 0/0, then drive pixel_valid with pixel (0, 0..15) -> pixel_color_valid 2 cycles later; pixel_color equals the ROM pattern for 0x41 rows 0..15; cursor_col = 1.
- Send COLS bytes 'x', then 0x0D, 0x08, 0x0A -> cursor steps wrap→(0,1), CR→(0,1), BS→(0,1), LF→(0,2); one bubble cycle after each printable byte.
- Fill to row ROWS-1 and send 0x0A -> char_ready = 0 for COLS+1 cycles; old row 1 appears at screen row 0; bottom row is blank; cursor (0, ROWS-1).
- With CURSOR_BLINK_FREQ such that the half period is 4 cycles and cursor_en = 1 -> cursor-cell bottom 2 lines toggle every 4 cycles; the identical cell with cursor_en = 0 never toggles.
- Assert clear_req together with char_valid → byte not accepted; clear runs; after it the byte is accepted at 0/0; assert rst mid-SCROLL → next cycle CLEAR, cursor 0/0.
